// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg: state encodings, default ROM timing and sizing helpers
package rom_port_arbiter_pkg;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam int DEF_SETUP_CYC = 3;
  localparam int DEF_ACCESS_CYC = 3;
  localparam int DEF_HOLD_CYC = 3;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  function automatic int cnt_w(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/rom_arb_timer.sv
// rom_arb_timer: loadable down-counter that flags when it has reached zero
module rom_arb_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = (cnt == '0);
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin sharing of the dual-address ROM between two cores
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 54,
  parameter int DATA_W = 128,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int ACCESS_CYC = DEF_ACCESS_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] rom_addr2,
  output logic              rom_notOE,
  output logic              rom_notOE2,
  output logic              rom_notCE,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);
  localparam int TW = cnt_w(max3(SETUP_CYC, ACCESS_CYC, HOLD_CYC));
  logic [2:0] state, nxt;
  logic sel, last_grant, grant1, win, load, tdone;
  logic [TW-1:0] load_val;
  rom_arb_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .done(tdone)
  );
  // On contention the core that did not win last time is granted
  assign grant1 = req1 && (!req0 || !last_grant);
  assign win = req0 || req1;
  always_comb begin
    nxt = (state == IDLE) ? (win ? SETUP : IDLE) :
          (state == SETUP) ? (tdone ? ACCESS : SETUP) :
          (state == ACCESS) ? (tdone ? HOLD : ACCESS) :
          (state == HOLD) ? (tdone ? DONE : HOLD) : IDLE;
    load = (nxt != state);
    load_val = (nxt == SETUP) ? TW'(SETUP_CYC - 1) :
               (nxt == ACCESS) ? TW'(ACCESS_CYC - 1) : TW'(HOLD_CYC - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= 1'b0;
      last_grant <= 1'b1;
      busy <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      rom_addr <= '0;
      rom_addr2 <= '0;
      rom_notOE <= 1'b1;
      rom_notOE2 <= 1'b1;
      rom_notCE <= 1'b1;
    end else begin
      state <= nxt;
      busy <= (nxt != IDLE);
      ack0 <= (state == HOLD) && tdone && !sel;
      ack1 <= (state == HOLD) && tdone && sel;
      if (state == IDLE && win) begin
        sel <= grant1;
        last_grant <= grant1;
        if (grant1) begin
          rom_addr2 <= addr1;
          rom_notOE2 <= 1'b0;
        end else begin
          rom_addr <= addr0;
          rom_notOE <= 1'b0;
        end
      end
      if (state == SETUP && tdone) rom_notCE <= 1'b0;
      if (state == ACCESS && tdone) begin
        rom_notCE <= 1'b1;
        if (sel) rdata1 <= rom_data;
        else rdata0 <= rom_data;
      end
      if (state == HOLD && tdone) begin
        rom_notOE <= 1'b1;
        rom_notOE2 <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed scoreboard bench with a behavioural ROM model
module tb_rom_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [53:0] addr0 = '0, addr1 = '0;
  logic ack0, ack1, busy, rom_notOE, rom_notOE2, rom_notCE;
  logic [127:0] rdata0, rdata1, rom_data;
  logic [53:0] rom_addr, rom_addr2;
  int errors = 0;
  int checks = 0;
  int ce_low_total = 0, oe_low_total = 0, oe2_low_total = 0;
  int hi_run = 0, last_gap = 0;
  typedef struct {
    logic port;
    logic [127:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rom_port_arbiter u_dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .addr0(addr0),
    .ack0(ack0),
    .rdata0(rdata0),
    .req1(req1),
    .addr1(addr1),
    .ack1(ack1),
    .rdata1(rdata1),
    .rom_addr(rom_addr),
    .rom_addr2(rom_addr2),
    .rom_notOE(rom_notOE),
    .rom_notOE2(rom_notOE2),
    .rom_notCE(rom_notCE),
    .rom_data(rom_data),
    .busy(busy)
  );

  function automatic logic [127:0] rom_word(input logic [53:0] a);
    logic [63:0] h;
    h = 64'((a + 54'd1) / 54'd2);
    return {h, 64'd18 - h};
  endfunction

  // The data bus only carries a word while the chip is enabled and one port is output-enabled
  assign rom_data = rom_notCE ? '0 :
                    !rom_notOE ? rom_word(rom_addr) :
                    !rom_notOE2 ? rom_word(rom_addr2) : '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic [127:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input logic port, input int lim, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(port ? ack1 : ack0) && cyc < lim);
    checks++;
    if (!(port ? ack1 : ack0)) begin
      errors++;
      $display("FAIL ack%0d_timeout: no ack after %0d cycles", port, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : monitor
    logic prev_ce, prev_rst;
    logic [109:0] prev_bus;
    exp_t e;
    prev_ce = 1'b1;
    prev_rst = 1'b1;
    prev_bus = '0;
    forever begin
      @(negedge clk);
      checks++;
      if (!rom_notOE && !rom_notOE2) begin
        errors++;
        $display("FAIL oe_both_low: notOE=%b notOE2=%b required not both 0", rom_notOE, rom_notOE2);
      end
      checks++;
      if (ack0 && ack1) begin
        errors++;
        $display("FAIL ack_both: ack0=%b ack1=%b required not both 1", ack0, ack1);
      end
      if (rom_notCE !== prev_ce && !reset && !prev_rst) begin
        checks++;
        if ({rom_addr, rom_addr2, rom_notOE, rom_notOE2} !== prev_bus) begin
          errors++;
          $display("FAIL ce_edge_stable: bus %0h changed from %0h at notCE edge",
                   {rom_addr, rom_addr2, rom_notOE, rom_notOE2}, prev_bus);
        end
      end
      if (!rom_notCE) ce_low_total++;
      if (!rom_notOE) oe_low_total++;
      if (!rom_notOE2) oe2_low_total++;
      if (rom_notCE) hi_run++;
      else begin
        if (prev_ce) last_gap = hi_run;
        hi_run = 0;
      end
      if (ack0 || ack1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: ack0=%b ack1=%b with nothing expected", ack0, ack1);
        end else begin
          e = exp_q.pop_front();
          if (ack1 !== e.port || (e.port ? rdata1 : rdata0) !== e.data) begin
            errors++;
            $display("FAIL sb_ack: port %0d data %0h expected port %0d data %0h",
                     ack1, ack1 ? rdata1 : rdata0, e.port, e.data);
          end
        end
      end
      prev_ce = rom_notCE;
      prev_rst = reset;
      prev_bus = {rom_addr, rom_addr2, rom_notOE, rom_notOE2};
    end
  end

  initial begin : stim
    int t, ce0, oe0, oe20;
    do_reset();
    chk("rst_notCE", 128'(rom_notCE), 128'd1);
    chk("rst_notOE", 128'(rom_notOE), 128'd1);
    chk("rst_notOE2", 128'(rom_notOE2), 128'd1);
    chk("rst_addr", 128'({rom_addr, rom_addr2}), 128'd0);
    chk("rst_rdata0", rdata0, 128'd0);
    chk("rst_rdata1", rdata1, 128'd0);
    chk("rst_acks_busy", 128'({ack0, ack1, busy}), 128'd0);
    // single core-0 fetch
    ce0 = ce_low_total;
    oe20 = oe2_low_total;
    addr0 = 54'd1;
    push(1'b0, {64'd1, 64'd17});
    req0 = 1'b1;
    wait_ack(1'b0, 30, t);
    req0 = 1'b0;
    chk("t1_latency", 128'(t), 128'd10);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_ce_low_cycles", 128'(ce_low_total - ce0), 128'd3);
    chk("t1_oe2_low_cycles", 128'(oe2_low_total - oe20), 128'd0);
    chk("t1_idle_busy", 128'(busy), 128'd0);
    // simultaneous requests after reset: core 0 first
    do_reset();
    addr0 = 54'd3;
    addr1 = 54'd5;
    push(1'b0, {64'd2, 64'd16});
    push(1'b1, {64'd3, 64'd15});
    req0 = 1'b1;
    req1 = 1'b1;
    wait_ack(1'b0, 30, t);
    req0 = 1'b0;
    chk("t2_latency0", 128'(t), 128'd10);
    wait_ack(1'b1, 30, t);
    req1 = 1'b0;
    chk("t2_spacing1", 128'(t), 128'd11);
    repeat (3) @(posedge clk);
    // both held continuously: strict alternation
    addr0 = 54'd10;
    addr1 = 54'd12;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, {64'd5, 64'd13});
      push(1'b1, {64'd6, 64'd12});
    end
    #1;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1'b0, 30, t);
      wait_ack(1'b1, 30, t);
      chk("t3_spacing", 128'(t), 128'd11);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // core 1 back-to-back
    oe0 = oe_low_total;
    addr1 = 54'd0;
    push(1'b1, {64'd0, 64'd18});
    push(1'b1, {64'd1, 64'd17});
    req1 = 1'b1;
    wait_ack(1'b1, 30, t);
    addr1 = 54'd2;
    wait_ack(1'b1, 30, t);
    req1 = 1'b0;
    chk("t4_spacing", 128'(t), 128'd11);
    checks++;
    if (last_gap < 8) begin
      errors++;
      $display("FAIL t4_ce_gap: got %0d required >= 8", last_gap);
    end
    chk("t4_oe_low_cycles", 128'(oe_low_total - oe0), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_rdata0_before", rdata0, {64'd5, 64'd13});
    // reset during the second ACCESS cycle
    addr0 = 54'd7;
    req0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_in_access", 128'(rom_notCE), 128'd0);
    reset = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_notCE", 128'(rom_notCE), 128'd1);
    chk("t5_oes", 128'({rom_notOE, rom_notOE2}), 128'd3);
    chk("t5_busy_ack", 128'({busy, ack0, ack1}), 128'd0);
    chk("t5_rdata0", rdata0, 128'd0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    addr0 = 54'd13;
    push(1'b0, {64'd7, 64'd11});
    req0 = 1'b1;
    wait_ack(1'b0, 30, t);
    req0 = 1'b0;
    chk("t5_after_latency", 128'(t), 128'd10);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the dual-address instruction ROM between core 0 and core 1.
- The ROM has two address buses, one shared notCE and one shared 128-bit data bus. Only one output enable may ever be low.
- This block arbitrates the two cores round-robin. It sequences notCE/notOE/notOE2 so the ROM setup/hold/width limits (25 ns) are met.
- It captures the 128-bit word and returns it to the winning core through a req/ack handshake.

Parameters:
- ADDR_W, 54, ROM address width.
- DATA_W, 128, ROM word width.
- SETUP_CYC, 3, cycles address/OE are stable before notCE falls (≥1).
- ACCESS_CYC, 3, cycles notCE is held low (≥1).
- HOLD_CYC, 3, cycles address/OE are held after notCE rises (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  core 0 fetch request; held high until ack0.
- addr0  in  ADDR_W  core 0 fetch address; stable while req0 is high.
- ack0  out  1  one-cycle pulse; rdata0 is valid.
- rdata0  out  DATA_W  core 0 fetched word; held until the next ack0.
- req1/addr1/ack1/rdata1: same as above, for core 1.
- rom_addr  out  ADDR_W  to ROM Address_bus.
- rom_addr2  out  ADDR_W  to ROM Address_bus2.
- rom_notOE  out  1  port 1 output enable, active low.
- rom_notOE2  out  1  port 2 output enable, active low.
- rom_notCE  out  1  chip enable, active low.
- rom_data  in  DATA_W  ROM Data_bus.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values:
  - rom_notCE, rom_notOE and rom_notOE2 = 1.
  - rom_addr, rom_addr2, rdata0 and rdata1 = 0.
  - ack0, ack1 and busy = 0.
  - State = IDLE; last_grant = 1, so core 0 wins first.
- IDLE:
  - Samples req0/req1.
  - If only one is high, that core wins.
  - If both are high, the core != last_grant wins.
  - On a win: latch sel and address; update last_grant; go to SETUP.
- SETUP (SETUP_CYC cycles):
  - The latched address drives the selected port's bus; the other bus keeps its previous value.
  - The selected OE is 0, the other OE is 1, and notCE is 1.
  - Then go to ACCESS.
- ACCESS (ACCESS_CYC cycles):
  - notCE = 0; address and OE are unchanged.
  - rom_data is captured into the sel rdata register on the edge that ends the last ACCESS cycle.
  - Then go to HOLD.
- HOLD (HOLD_CYC cycles):
  - notCE = 1; address and OE are unchanged.
  - Then go to DONE.
- DONE (1 cycle):
  - ack_sel = 1; both OEs = 1; notCE = 1.
  - No request is sampled in this cycle.
  - Then go to IDLE.
- Latency: ack is high in the cycle starting at edge SETUP_CYC+ACCESS_CYC+HOLD_CYC+1 after the IDLE edge that sampled req. With defaults that is edge 10.
  - Back-to-back throughput is one access per S+A+H+2 cycles.
  - Minimum notCE-high gap is H+2+S cycles.
- Timing counter: a down-counter is loaded with N-1 on state entry; the state exits when it reaches 0.
- Invariants:
  - rom_notOE and rom_notOE2 are never both 0.
  - notCE falls and rises only while address and OE are stable.
  - ack0 and ack1 are never both 1.
- A request dropped before its ack is a protocol violation. The access still completes, the ack still pulses, and rdata is still updated.
- Reset mid-operation: on the next edge all outputs take their reset values. No ack is issued and the rdata registers are cleared. The notCE low width may be violated; this is accepted.
- Fairness: with both requests continuously high, grants strictly alternate 0,1,0,1…

Decomposition:
- Include file rom_arb_defs.v holds:
  - state encodings: IDLE, SETUP, ACCESS, HOLD, DONE;
  - default timing constants: SETUP_CYC, ACCESS_CYC, HOLD_CYC.
- Sub-module rom_arb_timer: a loadable down-counter with load value and done flag, sized to the maximum of the three CYC parameters.
- The arbiter FSM, address/OE muxing and capture registers stay in rom_port_arbiter.

Test Plan:
- After reset, req0=1, addr0=1 -> ack0 at edge 10. rdata0 = {64'd1,64'd17}. rom_notOE2 = 1 throughout. rom_notCE = 0 for exactly 3 cycles.
- After reset, req0 and req1 both rise in the same cycle, addr0=3, addr1=5 -> ack0 first with rdata0 = {64'd2,64'd16}. ack1 follows 11 cycles later with rdata1 = {64'd3,64'd15}.
- req0 and req1 held continuously for 6 accesses -> ack order 0,1,0,1,0,1. The ROM specify block reports zero setup/hold/width violations.
- req1 only, back-to-back with addr1 = 0 then 2 -> acks spaced 11 cycles apart. The notCE-high gap between the two accesses is ≥8 cycles. rom_notOE stays 1.
- reset asserted during the 2nd ACCESS cycle -> next cycle notCE, notOE and notOE2 = 1 and busy = 0. No ack pulse; rdata0 = 0. A new req0 afterwards completes normally.
- Assertion monitor over all tests: never (rom_notOE==0 && rom_notOE2==0), and never (ack0 && ack1).
